// File: rtl/clock_gen_pkg.sv
// Shared types for the clock generator: lock sequencer state encoding and
// synchroniser limits.
package clock_gen_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_HOLD,
        ST_RUN,
        ST_LOST
    } pll_lock_state_e;

    localparam int PLL_SYNC_STAGES_MIN = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser; chain resets to 0, output is the last stage.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// PLL lock qualifier and downstream reset sequencer, one per PLL output clock.
// Optional loss counter / lock_lost_o pulse enabled by PLL_LOCK_LOSS_CNT_EN.
module pll_lock_reset_ctrl
    import clock_gen_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int STABLE_CYCLES     = 1024,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int LOSS_CNT_W        = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_async_i,
    input  logic                  lock_async_i,
    output logic                  clk_locked_o,
    output logic                  rst_o,
    output logic                  lock_lost_o,
    output logic [LOSS_CNT_W-1:0] loss_count_o,
    output logic [2:0]            state_o
);

    localparam int CNT_W = $clog2(max_int(STABLE_CYCLES, RESET_HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    if (SYNC_STAGES < PLL_SYNC_STAGES_MIN || STABLE_CYCLES < 1 || RESET_HOLD_CYCLES < 1) begin : g_param_check
        $error("pll_lock_reset_ctrl: SYNC_STAGES must be >= 2, STABLE_CYCLES and RESET_HOLD_CYCLES >= 1");
    end

    pll_lock_state_e  state;
    logic [CNT_W-1:0] cnt;
    logic             lock_sync;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk_i),
        .rst (reset_async_i),
        .d   (lock_async_i),
        .q   (lock_sync)
    );

    // One counter serves both the stability window and the reset hold.
    always_ff @(posedge clk_i or posedge reset_async_i) begin
        if (reset_async_i) begin
            state        <= ST_RESET;
            cnt          <= '0;
            clk_locked_o <= 1'b0;
            rst_o        <= 1'b1;
        end else begin
            case (state)
                ST_RESET: state <= ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                end
                ST_STABLE: begin
                    if (!lock_sync) begin
                        state <= ST_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state        <= ST_HOLD;
                        clk_locked_o <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!lock_sync) begin
                        state        <= ST_LOST;
                        clk_locked_o <= 1'b0;
                        rst_o        <= 1'b1;
                    end else if (cnt == HOLD_LAST) begin
                        state <= ST_RUN;
                        rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync) begin
                        state        <= ST_LOST;
                        clk_locked_o <= 1'b0;
                        rst_o        <= 1'b1;
                    end
                end
                ST_LOST: state <= ST_WAIT_LOCK;
                default: state <= ST_RESET;
            endcase
        end
    end

    assign state_o = state;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic loss_event;
    assign loss_event = ((state == ST_HOLD) || (state == ST_RUN)) && !lock_sync;

    // Saturates at all-ones; only reset_async_i clears it, relock does not.
    always_ff @(posedge clk_i or posedge reset_async_i) begin
        if (reset_async_i) begin
            lock_lost_o  <= 1'b0;
            loss_count_o <= '0;
        end else begin
            lock_lost_o <= loss_event;
            if (loss_event && (loss_count_o != '1))
                loss_count_o <= loss_count_o + 1'b1;
        end
    end
`else
    assign lock_lost_o  = 1'b0;
    assign loss_count_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Self-checking bench for pll_lock_reset_ctrl against a run-length reference model.
module tb_pll_lock_reset_ctrl;
    import clock_gen_pkg::*;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int LW     = 2;
`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_async_i = 1'b1;
    logic          lock_async_i = 1'b0;
    logic          clk_locked_o, rst_o, lock_lost_o;
    logic [LW-1:0] loss_count_o;
    logic [2:0]    state_o;

    pll_lock_reset_ctrl #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
        .RESET_HOLD_CYCLES(HOLD), .LOSS_CNT_W(LW)
    ) dut (
        .clk_i(clk_i), .reset_async_i(reset_async_i), .lock_async_i(lock_async_i),
        .clk_locked_o(clk_locked_o), .rst_o(rst_o), .lock_lost_o(lock_lost_o),
        .loss_count_o(loss_count_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    always @(posedge clk_i) edge_n <= edge_n + 1;

    // Reference: the FSM sees the input delayed by SYNC edges. Lock qualifies once
    // STABLE+1 consecutive delayed-high samples land on eligible edges (one for
    // leaving WAIT_LOCK, STABLE counted ones); one edge after reset or a loss is dead.
    logic [SYNC-1:0] m_hist;
    int              m_run, m_held, m_block;
    logic            m_locked, m_rst, m_lost;
    logic [LW-1:0]   m_cnt;
    wire             m_d = m_hist[SYNC-1];

    always @(posedge clk_i or posedge reset_async_i) begin
        if (reset_async_i) begin
            m_hist <= '0; m_run <= 0; m_held <= 0; m_block <= 1;
            m_locked <= 1'b0; m_rst <= 1'b1; m_lost <= 1'b0; m_cnt <= '0;
        end else begin
            m_hist <= {m_hist[SYNC-2:0], lock_async_i};
            m_lost <= 1'b0;
            if (m_locked) begin
                if (!m_d) begin
                    m_locked <= 1'b0; m_rst <= 1'b1; m_run <= 0; m_block <= 1;
                    if (CNT_EN) begin
                        m_lost <= 1'b1;
                        if (int'(m_cnt) < (1 << LW) - 1) m_cnt <= m_cnt + 1'b1;
                    end
                end else if (m_rst) begin
                    m_held <= m_held + 1;
                    if (m_held + 1 == HOLD) m_rst <= 1'b0;
                end
            end else if (m_block > 0) begin
                m_block <= m_block - 1; m_run <= 0;
            end else if (!m_d) begin
                m_run <= 0;
            end else if (m_run + 1 == STABLE + 1) begin
                m_locked <= 1'b1; m_held <= 0; m_run <= 0;
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    task automatic apply_reset(input logic lock_at_release);
        @(negedge clk_i);
        reset_async_i = 1'b1;
        lock_async_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_async_i = 1'b0;
        lock_async_i  = lock_at_release;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset_async_i = 1'b1;
        lock_async_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({clk_locked_o, rst_o, lock_lost_o, loss_count_o} !== 5'b01000 || state_o !== 3'(ST_RESET))
                $display("FAIL reset_values: got outs=%b state=%0d want outs=01000 state=%0d",
                         {clk_locked_o, rst_o, lock_lost_o, loss_count_o}, state_o, ST_RESET);
            else n_pass++;
        end
        reset_async_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (state_o !== 3'(ST_WAIT_LOCK) || rst_o !== 1'b1)
            $display("FAIL reset_release: got state=%0d rst=%b want state=%0d rst=1", state_o, rst_o, ST_WAIT_LOCK);
        else n_pass++;
    endtask

    task automatic test_clean_lock();
        int rise_lock = -1, fall_rst = -1, pulses = 0;
        apply_reset(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (clk_locked_o === 1'b1 && rise_lock < 0) rise_lock = i;
            if (rst_o === 1'b0 && fall_rst < 0) fall_rst = i;
            if (lock_lost_o !== 1'b0) pulses++;
            n_checks++;
            if ({clk_locked_o, rst_o, lock_lost_o, loss_count_o} !== {m_locked, m_rst, m_lost, m_cnt})
                $display("FAIL clean_model edge %0d: got %b want %b", i,
                         {clk_locked_o, rst_o, lock_lost_o, loss_count_o}, {m_locked, m_rst, m_lost, m_cnt});
            else n_pass++;
        end
        n_checks++;
        if (rise_lock !== 10) $display("FAIL clean_lock_edge: got %0d want 10", rise_lock); else n_pass++;
        n_checks++;
        if (fall_rst !== 14) $display("FAIL clean_rst_edge: got %0d want 14", fall_rst); else n_pass++;
        n_checks++;
        if (pulses !== 0) $display("FAIL clean_no_pulse: got %0d want 0", pulses); else n_pass++;
    endtask

    task automatic test_glitch();
        int rise_lock = -1, pulses = 0;
        apply_reset(1'b1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            if (clk_locked_o === 1'b1 && rise_lock < 0) rise_lock = i;
            if (lock_lost_o !== 1'b0) pulses++;
            n_checks++;
            if ({clk_locked_o, rst_o, lock_lost_o, loss_count_o} !== {m_locked, m_rst, m_lost, m_cnt})
                $display("FAIL glitch_model edge %0d: got %b want %b", i,
                         {clk_locked_o, rst_o, lock_lost_o, loss_count_o}, {m_locked, m_rst, m_lost, m_cnt});
            else n_pass++;
            if (i == 4) lock_async_i = 1'b0;
            if (i == 5) lock_async_i = 1'b1;
        end
        n_checks++;
        if (rise_lock !== 16) $display("FAIL glitch_lock_edge: got %0d want 16", rise_lock); else n_pass++;
        n_checks++;
        if (pulses !== 0 || loss_count_o !== '0)
            $display("FAIL glitch_no_loss: got pulses=%0d count=%0d want 0/0", pulses, loss_count_o);
        else n_pass++;
    endtask

    task automatic test_loss();
        int drop_at = -1, pulse_at = -1, pulses = 0, relock = -1, rst_fall = -1;
        apply_reset(1'b1);
        repeat (20) @(negedge clk_i);
        lock_async_i = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk_i);
            if (clk_locked_o === 1'b0 && drop_at < 0) drop_at = i;
            if (lock_lost_o === 1'b1) begin pulses++; pulse_at = i; end
            if (drop_at > 0 && clk_locked_o === 1'b1 && relock < 0) relock = i;
            if (relock > 0 && rst_o === 1'b0 && rst_fall < 0) rst_fall = i;
            n_checks++;
            if ({clk_locked_o, rst_o, lock_lost_o, loss_count_o} !== {m_locked, m_rst, m_lost, m_cnt})
                $display("FAIL loss_model edge %0d: got %b want %b", i,
                         {clk_locked_o, rst_o, lock_lost_o, loss_count_o}, {m_locked, m_rst, m_lost, m_cnt});
            else n_pass++;
            if (i == 4) lock_async_i = 1'b1;
        end
        n_checks++;
        if (drop_at !== 3) $display("FAIL loss_drop_edge: got %0d want 3", drop_at); else n_pass++;
        n_checks++;
        if (pulses !== (CNT_EN ? 1 : 0) || (CNT_EN && pulse_at !== 3))
            $display("FAIL loss_pulse: got %0d pulses at %0d want %0d at 3", pulses, pulse_at, CNT_EN ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (loss_count_o !== LW'(CNT_EN ? 1 : 0))
            $display("FAIL loss_count: got %0d want %0d", loss_count_o, CNT_EN ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (relock !== 15 || rst_fall !== 19)
            $display("FAIL loss_relock: got lock=%0d rst=%0d want 15/19", relock, rst_fall);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int pulses = 0;
        int want;
        apply_reset(1'b1);
        repeat (20) @(negedge clk_i);
        for (int k = 1; k <= 5; k++) begin
            lock_async_i = 1'b0;
            for (int i = 1; i <= 22; i++) begin
                @(negedge clk_i);
                if (lock_lost_o === 1'b1) pulses++;
                if (i == 3) begin
                    want = CNT_EN ? ((k < 3) ? k : 3) : 0;
                    n_checks++;
                    if (loss_count_o !== LW'(want))
                        $display("FAIL sat_count loss %0d: got %0d want %0d", k, loss_count_o, want);
                    else n_pass++;
                end
                if (i == 4) lock_async_i = 1'b1;
            end
        end
        n_checks++;
        if (pulses !== (CNT_EN ? 5 : 0)) $display("FAIL sat_pulses: got %0d want %0d", pulses, CNT_EN ? 5 : 0);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int waited = 0;
        apply_reset(1'b1);
        repeat (20) @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            lock_async_i = 1'b0;
            repeat (4) @(negedge clk_i);
            lock_async_i = 1'b1;
            if (k == 0) repeat (20) @(negedge clk_i);
        end
        while (clk_locked_o !== 1'b1 && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        @(negedge clk_i);
        n_checks++;
        if (state_o !== 3'(ST_HOLD) || loss_count_o !== LW'(CNT_EN ? 2 : 0))
            $display("FAIL mid_pre: got state=%0d count=%0d want %0d/%0d", state_o, loss_count_o,
                     ST_HOLD, CNT_EN ? 2 : 0);
        else n_pass++;
        #2 reset_async_i = 1'b1;
        #1;
        n_checks++;
        if ({clk_locked_o, rst_o, lock_lost_o, loss_count_o} !== 5'b01000 || state_o !== 3'(ST_RESET))
            $display("FAIL mid_reset: got outs=%b state=%0d want 01000/%0d",
                     {clk_locked_o, rst_o, lock_lost_o, loss_count_o}, state_o, ST_RESET);
        else n_pass++;
        @(negedge clk_i);
        reset_async_i = 1'b0;
    endtask

    task automatic test_random();
        int left = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({clk_locked_o, rst_o, lock_lost_o, loss_count_o} !== {m_locked, m_rst, m_lost, m_cnt})
                $display("FAIL random_model cycle %0d: got %b want %b", i,
                         {clk_locked_o, rst_o, lock_lost_o, loss_count_o}, {m_locked, m_rst, m_lost, m_cnt});
            else n_pass++;
            if (left == 0) begin
                lock_async_i = ~lock_async_i;
                left = lock_async_i ? int'($urandom_range(30, 1)) : int'($urandom_range(5, 1));
            end
            left--;
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch();
        test_loss();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
